instr_fetch_queue: RTL
======================

// Module: instr_fetch_queue
// PURPOSE
//  Parametrised instruction memory + fetch unit + instruction queue feeding the Tomasulo issue stage.
//  - Memory is loaded through a program port; no hierarchical initial loads.
//  - A PC sequencer reads one word per cycle into a FIFO.
//  - Issue stage pops entries with a valid/ready handshake.
//  - Supports backpressure, a redirect/flush, and program-length termination.
// PARAMETERS
//  INSTR_W  16  instruction width in bits
//  ADDR_W   4   PC/memory address width; memory depth = 2**ADDR_W
//  QDEPTH   4   queue entries; power of two, >= 2
// PORTS
//  clk1          in   1          clock; all logic on posedge
//  rst_n         in   1          reset, synchronous, active-low
//  prog_we       in   1          program write strobe
//  prog_addr     in   ADDR_W     program write address
//  prog_data     in   INSTR_W    program write data
//  prog_len      in   ADDR_W+1   number of valid instructions, 0..2**ADDR_W
//  start         in   1          pulse; begin fetching at PC 0
//  redirect      in   1          pulse; flush queue, resume at redirect_pc
//  redirect_pc   in   ADDR_W     new fetch PC
//  instr_valid   out  1          queue head valid
//  instr_ready   in   1          issue stage accepts head
//  instr_data    out  INSTR_W    head instruction
//  instr_pc      out  ADDR_W     PC of head instruction
//  pc_out        out  ADDR_W+1   next PC to fetch
//  count_out     out  $clog2(QDEPTH+1)  queue occupancy
//  busy          out  1          state is FETCH or DRAIN
//  done          out  1          state is DONE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - state=IDLE; pc, count, rd_ptr, wr_ptr = 0.
//   - All outputs 0; instr_data/instr_pc show entry 0 but are qualified by instr_valid.
//   - Memory and queue contents are not reset.
//   - Reset mid-operation aborts everything within that edge.
//  Program writes:
//   - prog_we accepted only in IDLE or DONE; ignored in FETCH/DRAIN.
//  States:
//   - IDLE: start -> FETCH, pc=0.
//   - FETCH: pc==prog_len -> DRAIN (prog_len=0 goes straight to DRAIN, then DONE).
//   - DRAIN: count==0 -> DONE.
//   - DONE: start -> FETCH, pc=0; program is re-runnable.
//  Fetch:
//   - Occurs in FETCH when pc<prog_len, count<QDEPTH, and redirect=0.
//   - Synchronous read: queue[wr_ptr] <= {mem[pc], pc}; wr_ptr++; pc++.
//   - One-edge latency: start at edge t0 -> first write at t1 -> instr_valid=1 after t1.
//  Dequeue:
//   - Fires when instr_valid & instr_ready: rd_ptr++.
//   - Head outputs are combinational from queue[rd_ptr].
//   - instr_valid = (count!=0).
//  Occupancy:
//   - Enqueue and dequeue in the same cycle leave count unchanged.
//   - Full queue blocks fetch; no enqueue while full, even if dequeuing. Only one bubble, no ready->write path.
//   - Pointers wrap modulo QDEPTH.
//  Redirect (FETCH, DRAIN or DONE; ignored in IDLE):
//   - count=0, rd_ptr=wr_ptr=0; any same-cycle dequeue and fetch are discarded.
//   - pc=redirect_pc.
//   - Next state: FETCH if redirect_pc<prog_len, else DONE.
//  Simultaneous events, priority: rst_n > redirect > start > fetch/dequeue.
//   - start is ignored in FETCH/DRAIN.
//  Widths:
//   - pc is ADDR_W+1 bits so pc==2**ADDR_W can mark the end.
//   - Memory is indexed by pc[ADDR_W-1:0].
// CONFIGURATION
//  PREDECODE_EN
//   - Defined: adds outputs instr_op[3:0]=instr_data[15:12], instr_rs1[3:0]=[11:8],
//     instr_rs2[3:0]=[7:4], instr_rd[3:0]=[3:0], and instr_illegal.
//   - instr_illegal=1 when op is not 0000 add / 0001 sub / 0010 mul.
//   - Requires INSTR_W==16 (elaboration error otherwise).
//   - Outputs are combinational from the head, 0 when instr_valid=0.
//   - Not defined: these ports are absent; behaviour is otherwise identical.
// TESTING
//  1. Load the 6-word program (0x2123,0x0345,0x0267,0x089A,0x27AB,0x1356), prog_len=6, start, ready=1
//     -> instr_data sequence 0x2123..0x1356, instr_pc 0..5, each accepted once; done=1 after the last pop.
//  2. Same program, ready=0 -> count saturates at 4, pc_out=4, busy=1.
//     Then ready=1 -> remaining words arrive in order, none lost or duplicated.
//  3. After 3 pops, assert redirect with redirect_pc=1 -> count=0 next cycle.
//     Then the next valid head is 0x0345 with pc 1, and the sequence continues through 5.
//  4. prog_we to addr 2 during FETCH -> memory unchanged (pc 2 still reads 0x0267).
//     In DONE, rewrite addr 2=0x1111, start -> third instr 0x1111.
//  5. prog_len=0, start -> DONE within 2 cycles, instr_valid never high.
//     Also: reset mid-FETCH -> all outputs 0, state IDLE.
//  6. PREDECODE_EN: head 0x2123 -> op=2, rs1=1, rs2=2, rd=3, illegal=0.
//     Head 0xF000 -> illegal=1.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// ============================================================================
// instr_fetch_queue
// ----------------------------------------------------------------------------
// This block combines an instruction memory, a PC sequencer and an
// instruction FIFO. The FIFO feeds the Tomasulo issue stage.
//
//   - The memory is loaded through the program port. Writes are accepted only
//     in IDLE or DONE.
//   - After start, the sequencer reads one word per cycle from PC 0 into the
//     FIFO. It stops when pc reaches prog_len, then drains the FIFO and
//     reports DONE.
//   - redirect flushes the FIFO and resumes fetching at redirect_pc.
//   - Reset is synchronous and active-low. Memory and FIFO contents are not
//     reset.
//
// Optional feature (macro PREDECODE_EN): adds predecoded head fields
// instr_op/instr_rs1/instr_rs2/instr_rd and instr_illegal. This requires
// INSTR_W == 16.
//
// Handshake: the head entry transfers on a rising edge where instr_valid and
// instr_ready are both 1. instr_valid does not depend on instr_ready. The head
// outputs hold steady until that transfer, or until a redirect or reset
// flushes the FIFO.
//
// Ports
//   clk1         in   clock, all logic on posedge
//   rst_n        in   synchronous active-low reset
//   prog_we      in   program write strobe
//   prog_addr    in   program write address
//   prog_data    in   program write data
//   prog_len     in   number of valid instructions (0 .. 2**ADDR_W)
//   start        in   pulse, begin fetching at PC 0 (IDLE/DONE only)
//   redirect     in   pulse, flush FIFO and resume at redirect_pc
//   redirect_pc  in   new fetch PC
//   instr_valid  out  FIFO head valid
//   instr_ready  in   issue stage accepts head
//   instr_data   out  head instruction
//   instr_pc     out  PC of head instruction
//   pc_out       out  next PC to fetch
//   count_out    out  FIFO occupancy
//   busy         out  state is FETCH or DRAIN
//   done         out  state is DONE
//   dbg_state    out  current FSM state (0 IDLE, 1 FETCH, 2 DRAIN, 3 DONE)
// ============================================================================
module instr_fetch_queue #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 4,
    parameter int QDEPTH  = 4
) (
    input  logic                         clk1,
    input  logic                         rst_n,
    input  logic                         prog_we,
    input  logic [ADDR_W-1:0]            prog_addr,
    input  logic [INSTR_W-1:0]           prog_data,
    input  logic [ADDR_W:0]              prog_len,
    input  logic                         start,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTR_W-1:0]           instr_data,
    output logic [ADDR_W-1:0]            instr_pc,
    output logic [ADDR_W:0]              pc_out,
    output logic [$clog2(QDEPTH+1)-1:0]  count_out,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   dbg_state
`ifdef PREDECODE_EN
    ,
    output logic [3:0]                   instr_op,
    output logic [3:0]                   instr_rs1,
    output logic [3:0]                   instr_rs2,
    output logic [3:0]                   instr_rd,
    output logic                         instr_illegal
`endif
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ADDR_W:0]      r_pc;
    logic [CNT_W-1:0]     r_count;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     r_wr_ptr;

    logic [INSTR_W-1:0]   r_mem    [2**ADDR_W];
    logic [INSTR_W-1:0]   r_q_data [QDEPTH];
    logic [ADDR_W-1:0]    r_q_pc   [QDEPTH];

    logic                 w_redirect_act;
    logic                 w_start_act;
    logic                 w_fetch;
    logic                 w_deq;
    logic                 w_prog_wr;
    logic                 w_redir_in_range;

    // Event qualification. Priority is redirect > start > fetch/dequeue.
    // A redirect in IDLE is ignored. Fetch is blocked whenever the FIFO is
    // full, even if a dequeue happens in the same cycle. This keeps
    // instr_ready out of the write path.
    assign w_redirect_act   = redirect && (r_state != S_IDLE);
    assign w_start_act      = start && !w_redirect_act &&
                              ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_fetch          = (r_state == S_FETCH) && (r_pc < prog_len) &&
                              (r_count != FULL_CNT) && !redirect;
    assign w_deq            = (r_count != '0) && instr_ready && !w_redirect_act;
    assign w_prog_wr        = prog_we && rst_n &&
                              ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_redir_in_range = ({1'b0, redirect_pc} < prog_len);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_redirect_act) begin
            w_state_nxt = w_redir_in_range ? S_FETCH : S_DONE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_state_nxt = S_FETCH;
                // With prog_len == 0 this goes straight to DRAIN.
                S_FETCH: if (r_pc >= prog_len) w_state_nxt = S_DRAIN;
                S_DRAIN: if (r_count == '0) w_state_nxt = S_DONE;
                S_DONE:  if (start) w_state_nxt = S_FETCH;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = (r_state == S_FETCH) || (r_state == S_DRAIN);
        done      = (r_state == S_DONE);
        dbg_state = r_state;
    end

    // ---------------- PC, pointers, occupancy ----------------
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_pc     <= '0;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (w_redirect_act) begin
            // The flush drops any same-cycle dequeue and fetch.
            r_pc     <= {1'b0, redirect_pc};
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_start_act) begin
                r_pc <= '0;
            end else if (w_fetch) begin
                r_pc <= r_pc + 1'b1;
            end
            // Pointer widths equal log2(QDEPTH), so they wrap naturally.
            if (w_fetch) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq)   r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_fetch, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- Storage (not reset) ----------------
    always_ff @(posedge clk1) begin
        if (w_prog_wr) begin
            r_mem[prog_addr] <= prog_data;
        end
        if (w_fetch && rst_n) begin
            r_q_data[r_wr_ptr] <= r_mem[r_pc[ADDR_W-1:0]];
            r_q_pc[r_wr_ptr]   <= r_pc[ADDR_W-1:0];
        end
    end

    // ---------------- Head outputs ----------------
    assign instr_valid = (r_count != '0);
    assign instr_data  = r_q_data[r_rd_ptr];
    assign instr_pc    = r_q_pc[r_rd_ptr];
    assign pc_out      = r_pc;
    assign count_out   = r_count;

`ifdef PREDECODE_EN
    if (INSTR_W != 16) begin : g_bad_instr_w
        $error("instr_fetch_queue: PREDECODE_EN requires INSTR_W == 16");
    end

    // Legal opcodes are 0000 add, 0001 sub and 0010 mul. Every field is
    // forced to 0 while the head is not valid.
    assign instr_op      = instr_valid ? instr_data[15:12] : 4'd0;
    assign instr_rs1     = instr_valid ? instr_data[11:8]  : 4'd0;
    assign instr_rs2     = instr_valid ? instr_data[7:4]   : 4'd0;
    assign instr_rd      = instr_valid ? instr_data[3:0]   : 4'd0;
    assign instr_illegal = instr_valid && (instr_data[15:12] > 4'd2);
`endif

endmodule
